// File: rtl/midi_rx_if.sv
// midi_rx_if: serial line in, received byte/strobes out
interface midi_rx_if;
  logic       midi_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_status;
  logic       rx_ferr;
  logic       rx_busy;
  modport master (input midi_in, output rx_data, rx_valid, rx_status, rx_ferr, rx_busy);
  modport slave  (output midi_in, input rx_data, rx_valid, rx_status, rx_ferr, rx_busy);
endinterface

// File: rtl/midi_rx.sv
// midi_rx: 31250 baud 8N1 receiver with start/stop validation and break hold-off
module midi_rx #(
  parameter int CLKS_PER_BIT = 256
) (
  input logic       clk,
  input logic       nreset,
  midi_rx_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d, data_q, data_d;
  logic          valid_q, valid_d, ferr_q, ferr_d, rxs;
  always_comb begin
    rxs     = sync_q[1];
    sync_d  = {sync_q[0], bus.midi_in};
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rxs ? IDLE : DATA;
      end
      DATA: if (cnt_q == LAST) begin
        cnt_d = '0;
        sh_d  = {rxs, sh_q[7:1]};
        idx_d = idx_q + 1'b1;
        if (idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_q == LAST) begin
        cnt_d   = '0;
        data_d  = rxs ? sh_q : data_q;
        valid_d = rxs;
        ferr_d  = !rxs;
        state_d = rxs ? IDLE : BRK;
      end
      BRK: begin
        // a held-low line must go high before another start bit is accepted
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end
  assign bus.rx_data   = data_q;
  assign bus.rx_status = data_q[7];
  assign bus.rx_valid  = valid_q;
  assign bus.rx_ferr   = ferr_q;
  assign bus.rx_busy   = state_q != IDLE;
endmodule
